// File: rtl/coin_acceptor_if.sv
// ----------------------------------------------------------------------------
// coin_acceptor_if : coin-mechanism side and vending-fsm side signal bundle
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface coin_acceptor_if;
  logic       coinSense;
  logic [1:0] coinType;
  logic       acceptEnable;
  logic       coinInserted;
  logic [3:0] money;
  logic       coinReject;
  logic       jam;

  modport master (
    output coinSense,
    output coinType,
    output acceptEnable,
    input  coinInserted,
    input  money,
    input  coinReject,
    input  jam
  );

  modport slave (
    input  coinSense,
    input  coinType,
    input  acceptEnable,
    output coinInserted,
    output money,
    output coinReject,
    output jam
  );
endinterface

`default_nettype wire

// File: rtl/coin_acceptor.sv
// ----------------------------------------------------------------------------
// coin_acceptor : synchronizes/debounces the coin sensor, classifies the coin
//                 and emits one accept or reject pulse per coin.
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module coin_acceptor #(
  parameter int         DEBOUNCE_CYCLES = 4,
  parameter int         JAM_CYCLES      = 64,
  parameter logic [3:0] VAL0            = 4'd1,
  parameter logic [3:0] VAL1            = 4'd2,
  parameter logic [3:0] VAL2            = 4'd4
) (
  input  wire logic       clock,
  input  wire logic       resetN,
  coin_acceptor_if.slave  bus
);

  localparam int CW = $clog2(JAM_CYCLES + 1);
  localparam logic [CW-1:0] c_deb_cycles = CW'(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] c_jam_cycles = CW'(JAM_CYCLES);
  localparam logic [CW-1:0] c_one        = CW'(1);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_DEBOUNCE = 3'd1,
    ST_PRESENT  = 3'd2,
    ST_RELEASE  = 3'd3,
    ST_JAM      = 3'd4
  } state_t;

  state_t          r_state;
  logic            r_sync1;
  logic            r_sync2;
  logic [CW-1:0]   r_count;
  logic [1:0]      r_type;
  logic            r_enable;
  logic            r_decide;
  logic            r_inserted;
  logic [3:0]      r_money;
  logic            r_reject;
  logic            r_jam;

  logic            w_sense;
  logic [CW-1:0]   w_count_inc;
  logic            w_type_valid;
  logic [3:0]      w_value;

  assign w_sense     = r_sync2;
  assign w_count_inc = (r_count == {CW{1'b1}}) ? r_count : r_count + c_one;

  always_comb begin
    w_type_valid = 1'b1;
    w_value      = 4'd0;
    case (r_type)
      2'b00:   w_value = VAL0;
      2'b01:   w_value = VAL1;
      2'b10:   w_value = VAL2;
      default: w_type_valid = 1'b0;
    endcase
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      r_state    <= ST_IDLE;
      r_sync1    <= 1'b0;
      r_sync2    <= 1'b0;
      r_count    <= '0;
      r_type     <= 2'b00;
      r_enable   <= 1'b0;
      r_decide   <= 1'b0;
      r_inserted <= 1'b0;
      r_money    <= 4'd0;
      r_reject   <= 1'b0;
      r_jam      <= 1'b0;
    end else begin
      r_sync1    <= bus.coinSense;
      r_sync2    <= r_sync1;
      r_inserted <= 1'b0;
      r_reject   <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          if (w_sense) begin
            r_state <= ST_DEBOUNCE;
            r_count <= c_one;
          end else begin
            r_count <= '0;
          end
        end

        ST_DEBOUNCE: begin
          if (!w_sense) begin
            r_state <= ST_IDLE;
            r_count <= '0;
          end else begin
            r_count <= w_count_inc;
            // Type and enable are frozen here so later changes cannot affect this coin.
            if (w_count_inc >= c_deb_cycles) begin
              r_type   <= bus.coinType;
              r_enable <= bus.acceptEnable;
              r_state  <= ST_PRESENT;
            end
          end
        end

        ST_PRESENT: begin
          if (!w_sense) begin
            r_state  <= ST_RELEASE;
            r_count  <= '0;
            r_decide <= 1'b1;
          end else if (w_count_inc >= c_jam_cycles) begin
            r_state <= ST_JAM;
            r_count <= '0;
            r_jam   <= 1'b1;
          end else begin
            r_count <= w_count_inc;
          end
        end

        ST_RELEASE: begin
          // Decision is registered one edge after the fall is seen.
          if (r_decide) begin
            r_decide <= 1'b0;
            if (w_type_valid && r_enable) begin
              r_inserted <= 1'b1;
              r_money    <= w_value;
            end else begin
              r_reject <= 1'b1;
            end
          end
          if (w_sense) begin
            r_count <= '0;
          end else if (w_count_inc >= c_deb_cycles) begin
            r_state <= ST_IDLE;
            r_count <= '0;
          end else begin
            r_count <= w_count_inc;
          end
        end

        ST_JAM: begin
          if (w_sense) begin
            r_count <= '0;
          end else if (w_count_inc >= c_deb_cycles) begin
            r_state  <= ST_IDLE;
            r_count  <= '0;
            r_jam    <= 1'b0;
            r_reject <= 1'b1;
          end else begin
            r_count <= w_count_inc;
          end
        end

        default: begin
          r_state  <= ST_IDLE;
          r_count  <= '0;
          r_decide <= 1'b0;
          r_jam    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.coinInserted = r_inserted;
  assign bus.money        = r_money;
  assign bus.coinReject   = r_reject;
  assign bus.jam          = r_jam;

endmodule

`default_nettype wire

// File: doc/coin_acceptor.md
Name: coin_acceptor

Overview:
Front-end stage of the vending machine that converts a raw coin-mechanism sensor into the clean one-cycle coinInserted pulse and 4-bit money value consumed by the vending fsm. It synchronizes and debounces the sensor, classifies the coin from a type code, and rejects invalid, jammed or disallowed coins. Its outputs connect directly to the fsm's coinInserted and money inputs.

Parameters:
DEBOUNCE_CYCLES, 4, consecutive synchronized-high cycles needed to qualify a coin, and consecutive low cycles needed to re-arm.
JAM_CYCLES, 64, cycles of continuous presence (counted from DEBOUNCE entry) that declare a jam; must be > DEBOUNCE_CYCLES.
VAL0, 4'd1, money value for coinType 2'b00.
VAL1, 4'd2, money value for coinType 2'b01.
VAL2, 4'd4, money value for coinType 2'b10. coinType 2'b11 is invalid.

Ports:
clock  input  1  system clock, rising edge
resetN  input  1  asynchronous, active-low reset
coinSense  input  1  raw, asynchronous coin-present sensor, high while a coin is in the chute
coinType  input  2  coin classification from the mechanism, stable while coinSense is high
acceptEnable  input  1  synchronous; 0 = refuse coins (fsm busy dispensing)
coinInserted  output  1  one-cycle pulse: coin accepted
money  output  4  value of the last accepted coin, valid with coinInserted and held afterwards
coinReject  output  1  one-cycle pulse: coin routed to the return chute
jam  output  1  level, high while in JAM

Behaviour:
- Reset (asynchronous assert): state IDLE; counter, synchronizer, latched type, coinInserted, money, coinReject and jam all 0. Release is sampled on the clock. Reset mid-coin discards the coin and produces no pulse.
- coinSense passes through a 2-flop synchronizer; "sense" below means the synchronized value. coinType is sampled only at qualification.
- Counter width is clog2(JAM_CYCLES+1) bits. It saturates and never wraps.
- IDLE: on sense=1, go to DEBOUNCE with count=1.
- DEBOUNCE:
  - sense=0 → IDLE. This is a glitch: no pulse.
  - Otherwise count++. On the cycle count reaches DEBOUNCE_CYCLES, latch coinType and acceptEnable, then go to PRESENT.
- PRESENT: count++ each cycle.
  - Count reaching JAM_CYCLES while sense=1 → JAM.
  - sense=0 → RELEASE with count cleared. On the next edge the decision pulse is registered:
    - Latched type valid AND latched acceptEnable=1: coinInserted=1 for exactly one cycle, and money is loaded with VALn in the same cycle.
    - Otherwise: coinReject=1 for one cycle, and money is unchanged.
- RELEASE:
  - sense=1 clears count (bounce is ignored and no new coin is started).
  - sense=0 increments count. When it reaches DEBOUNCE_CYCLES → IDLE.
- JAM:
  - jam=1. sense=1 holds count at 0.
  - sense=0 counts up. On reaching DEBOUNCE_CYCLES: one coinReject pulse, jam=0, go to IDLE. No credit is given.
- Latency: coinInserted/coinReject rise on the 4th rising edge after coinSense falls: 2 for the synchronizer, 1 for the state change, 1 for the registered output.
- Minimum coin spacing: DEBOUNCE_CYCLES low cycles after release. A coin arriving earlier is absorbed as bounce.
- Mutual exclusion: coinInserted and coinReject are never high together, and at most one pulse is emitted per coin.
- acceptEnable changing after qualification has no effect on that coin.
- Unused/illegal state encodings return to IDLE.

Test Plan:
- Valid coin: coinType=2'b10, acceptEnable=1, coinSense high 10 cycles then low → one coinInserted pulse 4 edges after the fall, money=4'd4 and held; coinReject stays 0.
- Glitch: coinSense high 2 cycles (less than DEBOUNCE_CYCLES=4) → no pulse, state returns to IDLE, money unchanged.
- Invalid/disabled: coinType=2'b11, sensed 8 cycles → coinReject pulse, money unchanged. Repeat with coinType=2'b00, acceptEnable=0 at qualification → coinReject pulse only.
- Jam: coinSense held high 70 cycles → jam=1 once count hits 64; after release plus 4 low cycles → one coinReject pulse, jam=0, no coinInserted.
- Bounce/back-to-back: valid coin (type 2'b01), then coinSense toggles 1-1-0-1 within RELEASE → ignored. Then a clean coin of type 2'b00 → second coinInserted pulse, money=4'd1.
- Reset mid-coin: resetN low during PRESENT → outputs 0 immediately without waiting for a clock edge; after release with coinSense=0 there is no pulse. A following coin is accepted normally.
